// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, purely combinational. The serial adder
// reuses one instance of this cell for every bit position.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p;

    // Sum and carry from the propagate term
    always_comb begin
        p  = a ^ b;
        s  = p ^ cin;
        co = (a & b) | (cin & p);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, processed LSB first, one bit
// per clock through a single full_adder cell, with a start/busy/done
// handshake.
//
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input; sub=1 makes
// the block compute a - b (b inverted, carry forced to 1, cout=1 means no
// borrow).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last completed result
// RUN   | one bit per cycle through the full adder, WIDTH cycles in total
// DONE  | done pulse; sum/cout just updated; a new start is accepted here
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             fa_s;
    logic             fa_co;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Operand conditioning at load time: subtraction is a + ~b + 1
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load     = b;
        carry_load = cin;
    end
`endif

    // Start is honoured in IDLE and in DONE (back-to-back), never in RUN
    always_comb begin
        accept   = start && (state_q != RUN);
        last_bit = (state_q == RUN) && (cnt_q == LAST);
    end

    // Result shift register input: new sum bit enters at the MSB. Written
    // as shift-then-overwrite so WIDTH=1 needs no special slice.
    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = fa_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, decoded from the registered state
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shifters, carry flop and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_next;
            carry_q <= fa_co;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Visible result: loaded only on the edge that enters DONE, so it is
    // stable throughout RUN and holds until the next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_bit) begin
            sum  <= res_next;
            cout <= fa_co;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a WIDTH=1 and a WIDTH=8 instance,
// directed cases plus random operands checked against plain arithmetic.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8, sub1;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] last_res8 = '0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle after a completion; done must already be gone
    task automatic idle8();
        start8 = 1'b0;
        tick();
        chk("done8_single_pulse", 64'(done8), 64'd0);
    endtask

    // Reference: plain arithmetic on the operands
    function automatic logic [8:0] model8(input logic [7:0] av, input logic [7:0] bv,
                                          input logic cv, input logic sv);
        logic [8:0] r;
        if (sv) begin
            r[7:0] = av - bv;
            r[8]   = (av >= bv);
        end else begin
            r = 9'(av) + 9'(bv) + 9'(cv);
        end
        return r;
    endfunction

    // Issue one 8-bit operation from the current cycle and follow it to done.
    // Returns in the DONE cycle so the caller may start again back-to-back.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic sv, input bit ign);
        int         cyc;
        int         busy_n;
        logic [8:0] exp;
        exp    = model8(av, bv, cv, sv);
        a8     = av;
        b8     = bv;
        cin8   = cv;
`ifdef SERIAL_ADDER_SUB_EN
        sub8   = sv;
`endif
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        cyc    = 1;
        busy_n = 0;
        while (!done8 && cyc < 40) begin
            if (busy8) busy_n++;
            chk("result_hold_during_run", 64'({cout8, sum8}), 64'(last_res8));
            if (ign && cyc == 3) begin
                start8 = 1'b1;
                a8     = 8'hAA;
                b8     = 8'h55;
            end else begin
                start8 = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("latency8", 64'(cyc), 64'd9);
        chk("busy8_cycles", 64'(busy_n), 64'd8);
        chk("busy8_low_in_done", 64'(busy8), 64'd0);
        chk("sum8", 64'(sum8), 64'(exp[7:0]));
        chk("cout8", 64'(cout8), 64'(exp[8]));
        last_res8 = exp;
    endtask

    task automatic op1(input logic av, input logic bv, input logic cv);
        int         cyc;
        logic [1:0] exp;
        exp    = 2'(av) + 2'(bv) + 2'(cv);
        a1     = av;
        b1     = bv;
        cin1   = cv;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc    = 1;
        while (!done1 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("latency1", 64'(cyc), 64'd2);
        chk("sum1", 64'(sum1), 64'(exp[0]));
        chk("cout1", 64'(cout1), 64'(exp[1]));
        tick();
        chk("done1_single_pulse", 64'(done1), 64'd0);
    endtask

    initial begin
        int         dn;
        logic [7:0] ra, rb;
        logic       rc, rs;

        rst    = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8   = 1'b0; sub1 = 1'b0;
`endif
        tick();
        tick();
        chk("reset_busy8", 64'(busy8), 64'd0);
        chk("reset_done8", 64'(done8), 64'd0);
        chk("reset_sum8", 64'(sum8), 64'd0);
        chk("reset_cout8", 64'(cout8), 64'd0);
        chk("reset_busy1", 64'(busy1), 64'd0);
        chk("reset_sum1", 64'(sum1), 64'd0);
        rst = 1'b0;
        tick();

        // WIDTH=1 exhaustive over {a,b,cin}
        for (int i = 0; i < 8; i++) begin
            op1(i[2], i[1], i[0]);
        end

        // Full carry ripple through every bit
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        idle8();

        // Carry-in used, then back-to-back start in the DONE cycle
        op8(8'h3C, 8'h0F, 1'b1, 1'b0, 1'b0);
        op8(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        idle8();

        // Start pulse while busy must be ignored
        op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        idle8();
        tick();

        // Reset in RUN cycle 4 aborts with no done pulse
        a8     = 8'h77;
        b8     = 8'h66;
        cin8   = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        chk("busy8_before_abort", 64'(busy8), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy8", 64'(busy8), 64'd0);
        chk("abort_done8", 64'(done8), 64'd0);
        chk("abort_sum8", 64'(sum8), 64'd0);
        chk("abort_cout8", 64'(cout8), 64'd0);
        last_res8 = '0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);
        op8(8'h5A, 8'h33, 1'b1, 1'b0, 1'b0);
        idle8();

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        idle8();
        op8(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
        idle8();
`endif

        // Random operands, randomly back-to-back or separated by idle
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            op8(ra, rb, rc, rs, 1'b0);
            if ($urandom_range(1, 0) == 1) idle8();
        end
        idle8();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
